// File: rtl/fib_result_collector.sv
// fib_result_collector: watches the upstream counter/sampler outputs, records one
// {m, n, run cycles} result per completed run into a small FIFO with a valid/ready
// drain port, and flags m >= n completions and dropped records.
module fib_result_collector #(
   parameter int unsigned W     = 19,
   parameter int unsigned CW    = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   src_rst,
   input  logic [W-1:0]           x_in,
   input  logic [W-1:0]           m_in,
   input  logic [W-1:0]           n_in,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [W-1:0]           res_m,
   output logic [W-1:0]           res_n,
   output logic [CW-1:0]          res_cycles,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   inv_err,
   output logic                   overflow
);

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNTW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [W-1:0]  m;
      logic [W-1:0]  n;
      logic [CW-1:0] cycles;
   } rec_t;

   logic            done_q;
   logic [CW-1:0]   cyc_q;
   rec_t            mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CNTW-1:0] count_q;

   logic done_now;
   logic evt;
   logic full;
   logic empty;
   logic pop;
   logic push;

   // Completion detection and FIFO handshake decode.
   always_comb begin
      done_now = (x_in >= n_in);
      evt      = !src_rst && done_now && !done_q;
      full     = (count_q == CNTW'(DEPTH));
      empty    = (count_q == CNTW'(0));
      pop      = !empty && res_ready;
      push     = evt && (!full || pop);
   end

   // Per-run tracking: saturating count of not-yet-done cycles and done edge history.
   always_ff @(posedge clk) begin
      if (rst || src_rst) begin
         done_q <= 1'b0;
         cyc_q  <= '0;
      end else begin
         done_q <= done_now;
         if (!done_now && (cyc_q != {CW{1'b1}}))
            cyc_q <= cyc_q + CW'(1);
      end
   end

   // Result FIFO storage, pointers, occupancy and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         inv_err  <= 1'b0;
         overflow <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{m: m_in, n: n_in, cycles: cyc_q};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNTW'(1);
            2'b01:   count_q <= count_q - CNTW'(1);
            default: count_q <= count_q;
         endcase
         if (evt && full && !pop)
            overflow <= 1'b1;
         if (evt && !(m_in < n_in))
            inv_err <= 1'b1;
      end
   end

   // Head view; outputs read as zero while the FIFO is empty.
   always_comb begin
      res_valid  = !empty;
      fifo_count = count_q;
      res_m      = empty ? '0 : mem[rd_ptr].m;
      res_n      = empty ? '0 : mem[rd_ptr].n;
      res_cycles = empty ? '0 : mem[rd_ptr].cycles;
   end

endmodule

// File: tb/tb_fib_result_collector.sv
// Scoreboard bench for fib_result_collector: each driven run pushes its expected
// record; records are compared at the FIFO head as they are drained.
module tb_fib_result_collector;

   localparam int unsigned W     = 19;
   localparam int unsigned CW    = 16;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      int m;
      int n;
      int cycles;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   src_rst;
   logic [W-1:0]           x_in;
   logic [W-1:0]           m_in;
   logic [W-1:0]           n_in;
   logic                   res_valid;
   logic                   res_ready;
   logic [W-1:0]           res_m;
   logic [W-1:0]           res_n;
   logic [CW-1:0]          res_cycles;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   inv_err;
   logic                   overflow;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   bit   exp_ovf = 1'b0;
   bit   exp_inv = 1'b0;

   fib_result_collector #(.W(W), .CW(CW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .src_rst    (src_rst),
      .x_in       (x_in),
      .m_in       (m_in),
      .n_in       (n_in),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_m      (res_m),
      .res_n      (res_n),
      .res_cycles (res_cycles),
      .fifo_count (fifo_count),
      .inv_err    (inv_err),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Compare the head outputs with the oldest expected record.
   task automatic check_head();
      check("head_valid", int'(res_valid), 1);
      if (sb.size() > 0) begin
         check("head_m", int'(res_m), sb[0].m);
         check("head_n", int'(res_n), sb[0].n);
         check("head_cycles", int'(res_cycles), sb[0].cycles);
      end
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_count"}, int'(fifo_count), sb.size());
      check({tag, "_ovf"}, int'(overflow), int'(exp_ovf));
      check({tag, "_inv"}, int'(inv_err), int'(exp_inv));
   endtask

   // One run: src_rst pulse, then x steps 0..n, m tracks x and ends at mfin.
   task automatic run(input int n, input int mfin, input bit pop_end);
      src_rst = 1'b1;
      @(negedge clk);
      src_rst = 1'b0;
      for (int x = 0; x <= n; x++) begin
         x_in = W'(x);
         n_in = W'(n);
         m_in = (x == n) ? W'(mfin) : W'(x);
         if (x == n) begin
            int s;
            s = sb.size();
            check("pre_push_valid", int'(res_valid), (s > 0) ? 1 : 0);
            if (pop_end && s > 0) begin
               check_head();
               void'(sb.pop_front());
               res_ready = 1'b1;
            end
            if (sb.size() < DEPTH)
               sb.push_back('{m: mfin, n: n, cycles: n});
            else
               exp_ovf = 1'b1;
            if (!(mfin < n))
               exp_inv = 1'b1;
         end
         @(negedge clk);
         res_ready = 1'b0;
      end
      check_flags("run");
   endtask

   // Pop every expected record in order, one per cycle.
   task automatic drain();
      for (int k = 0; k < 2 * DEPTH && sb.size() > 0; k++) begin
         check_head();
         void'(sb.pop_front());
         res_ready = 1'b1;
         @(negedge clk);
      end
      res_ready = 1'b0;
      check("drain_valid", int'(res_valid), 0);
      check("drain_count", int'(fifo_count), 0);
      check("empty_res_m", int'(res_m), 0);
      check("empty_res_cycles", int'(res_cycles), 0);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      src_rst   = 1'b0;
      res_ready = 1'b0;
      x_in      = '0;
      m_in      = '0;
      n_in      = W'(200);
      @(negedge clk);
      @(negedge clk);
      sb.delete();
      exp_ovf = 1'b0;
      exp_inv = 1'b0;
      check("rst_valid", int'(res_valid), 0);
      check("rst_res_n", int'(res_n), 0);
      check_flags("rst");
      rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // Long run: record {199,200,200}, no bypass, no re-fire while held at done.
      run(200, 199, 1'b0);
      repeat (50) @(negedge clk);
      check("hold_count", int'(fifo_count), 1);
      drain();

      // Five runs into a four-deep FIFO: fifth dropped, overflow set.
      for (int i = 0; i < 5; i++)
         run(5 + i, i, 1'b0);
      drain();

      // m == n completion: record kept, inv_err sticky across later runs.
      run(20, 20, 1'b0);
      run(10, 3, 1'b0);
      drain();
      check("inv_sticky", int'(inv_err), 1);

      // Full FIFO with pop coinciding with completion.
      do_reset();
      for (int i = 1; i <= 4; i++)
         run(7 + i, i, 1'b0);
      run(12, 5, 1'b1);
      drain();

      // n = 0 run completes on the first cycle after src_rst with cycles = 0.
      src_rst = 1'b1;
      @(negedge clk);
      src_rst = 1'b0;
      x_in    = '0;
      n_in    = '0;
      m_in    = W'(7);
      check("n0_no_bypass", int'(res_valid), 0);
      sb.push_back('{m: 7, n: 0, cycles: 0});
      exp_inv = 1'b1;
      @(negedge clk);
      check_head();
      check_flags("n0");
      repeat (3) @(negedge clk);
      check("n0_no_refire", int'(fifo_count), 1);
      run(6, 2, 1'b0);

      // Reset in the middle of a drain clears everything next cycle.
      check_head();
      void'(sb.pop_front());
      res_ready = 1'b1;
      @(negedge clk);
      check("mid_drain_count", int'(fifo_count), 1);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_valid", int'(res_valid), 0);
      check("mrst_count", int'(fifo_count), 0);
      check("mrst_m", int'(res_m), 0);
      check("mrst_n", int'(res_n), 0);
      check("mrst_cycles", int'(res_cycles), 0);
      check("mrst_inv", int'(inv_err), 0);
      check("mrst_ovf", int'(overflow), 0);
      rst       = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
